// File: rtl/fp_align_stage.sv
// Exponent-compare / mantissa-align stage of the FP adder: orders the operand pair by magnitude
// and right-shifts the smaller mantissa. Define FPALIGN_GRS_EN to add the SML_GRS guard/round/sticky output.
module fp_align_stage #(
    parameter int MW = 24,
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [MW-1:0] a1,
    input  logic [MW-1:0] b1,
    input  logic [EW-1:0] ae1,
    input  logic [EW-1:0] be1,
    input  logic          as1,
    input  logic          bs1,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MW-1:0] big_m,
    output logic [MW-1:0] sml_m,
    output logic [EW-1:0] exp,
    output logic          big_s,
    output logic          eff_sub,
`ifdef FPALIGN_GRS_EN
    output logic [2:0]    sml_grs,
`endif
    output logic          swap
);

    // Stage 1: ordered operands plus exponent difference
    logic          s1_v_q, s1_v_d;
    logic [MW-1:0] s1_big_q, s1_big_d;
    logic [MW-1:0] s1_sml_q, s1_sml_d;
    logic [EW-1:0] s1_diff_q, s1_diff_d;
    logic [EW-1:0] s1_exp_q, s1_exp_d;
    logic          s1_bs_q, s1_bs_d;
    logic          s1_eff_q, s1_eff_d;
    logic          s1_swap_q, s1_swap_d;

    // Stage 2: aligned result
    logic          s2_v_q, s2_v_d;
    logic [MW-1:0] s2_big_q, s2_big_d;
    logic [MW-1:0] s2_sml_q, s2_sml_d;
    logic [EW-1:0] s2_exp_q, s2_exp_d;
    logic          s2_bs_q, s2_bs_d;
    logic          s2_eff_q, s2_eff_d;
    logic          s2_swap_q, s2_swap_d;
    logic [2:0]    s2_grs_q, s2_grs_d;

    logic          s2_load;
    logic          accept;
    logic          a_big;
    logic [MW-1:0] sml_shift;
    logic [2:0]    grs;

    assign s2_load  = !s2_v_q || out_ready;
    assign in_ready = !s1_v_q || s2_load;
    assign accept   = in_valid && in_ready;

    // Full tie (equal exponent and mantissa) keeps A in the big slot.
    assign a_big = (ae1 > be1) || ((ae1 == be1) && (a1 >= b1));

`ifdef FPALIGN_GRS_EN
    localparam int XW = 2 * MW + 2;
    localparam logic [EW:0] GRS_LIM = (EW + 1)'(MW + 2);
    logic [XW-1:0] ext;

    // The MW+2 zero bits below the mantissa catch every bit shifted out for DIFF <= MW+1.
    always_comb begin
        ext       = {s1_sml_q, {(MW + 2){1'b0}}} >> s1_diff_q;
        sml_shift = ext[XW-1 -: MW];
        if ({1'b0, s1_diff_q} >= GRS_LIM)
            grs = {2'b00, |s1_sml_q};
        else
            grs = {ext[MW+1], ext[MW], |ext[MW-1:0]};
    end

    assign sml_grs = s2_grs_q;
`else
    always_comb begin
        sml_shift = s1_sml_q >> s1_diff_q;
        grs       = 3'b000;
    end
`endif

    always_comb begin
        s1_v_d    = s1_v_q;
        s1_big_d  = s1_big_q;
        s1_sml_d  = s1_sml_q;
        s1_diff_d = s1_diff_q;
        s1_exp_d  = s1_exp_q;
        s1_bs_d   = s1_bs_q;
        s1_eff_d  = s1_eff_q;
        s1_swap_d = s1_swap_q;
        if (in_ready)
            s1_v_d = in_valid;
        if (accept) begin
            s1_big_d  = a_big ? a1 : b1;
            s1_sml_d  = a_big ? b1 : a1;
            s1_diff_d = a_big ? (ae1 - be1) : (be1 - ae1);
            s1_exp_d  = a_big ? ae1 : be1;
            s1_bs_d   = a_big ? as1 : bs1;
            s1_eff_d  = as1 ^ bs1;
            s1_swap_d = !a_big;
        end
    end

    always_comb begin
        s2_v_d    = s2_v_q;
        s2_big_d  = s2_big_q;
        s2_sml_d  = s2_sml_q;
        s2_exp_d  = s2_exp_q;
        s2_bs_d   = s2_bs_q;
        s2_eff_d  = s2_eff_q;
        s2_swap_d = s2_swap_q;
        s2_grs_d  = s2_grs_q;
        if (s2_load)
            s2_v_d = s1_v_q;
        if (s2_load && s1_v_q) begin
            s2_big_d  = s1_big_q;
            s2_sml_d  = sml_shift;
            s2_exp_d  = s1_exp_q;
            s2_bs_d   = s1_bs_q;
            s2_eff_d  = s1_eff_q;
            s2_swap_d = s1_swap_q;
            s2_grs_d  = grs;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_big_q  <= '0;
            s1_sml_q  <= '0;
            s1_diff_q <= '0;
            s1_exp_q  <= '0;
            s1_bs_q   <= 1'b0;
            s1_eff_q  <= 1'b0;
            s1_swap_q <= 1'b0;
            s2_v_q    <= 1'b0;
            s2_big_q  <= '0;
            s2_sml_q  <= '0;
            s2_exp_q  <= '0;
            s2_bs_q   <= 1'b0;
            s2_eff_q  <= 1'b0;
            s2_swap_q <= 1'b0;
            s2_grs_q  <= 3'b000;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_big_q  <= s1_big_d;
            s1_sml_q  <= s1_sml_d;
            s1_diff_q <= s1_diff_d;
            s1_exp_q  <= s1_exp_d;
            s1_bs_q   <= s1_bs_d;
            s1_eff_q  <= s1_eff_d;
            s1_swap_q <= s1_swap_d;
            s2_v_q    <= s2_v_d;
            s2_big_q  <= s2_big_d;
            s2_sml_q  <= s2_sml_d;
            s2_exp_q  <= s2_exp_d;
            s2_bs_q   <= s2_bs_d;
            s2_eff_q  <= s2_eff_d;
            s2_swap_q <= s2_swap_d;
            s2_grs_q  <= s2_grs_d;
        end
    end

    assign out_valid = s2_v_q;
    assign big_m     = s2_big_q;
    assign sml_m     = s2_sml_q;
    assign exp       = s2_exp_q;
    assign big_s     = s2_bs_q;
    assign eff_sub   = s2_eff_q;
    assign swap      = s2_swap_q;

endmodule
